// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by the UART TX device and its integrity generator.
// Field layout follows the 32-bit single-beat subset used by the Ibex playground.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_DBW = 4;
    localparam int unsigned TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_rsp_intg_gen.sv
// Response integrity generator: passes the D channel through and fills d_user with
// 7-bit interleaved parity over the response header and over the data word.
module tlul_rsp_intg_gen (
    input  tlul_pkg::tl_d2h_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o
);

    function automatic logic [6:0] fold7(input logic [56:0] v);
        logic [6:0] p;
        p = '0;
        for (int b = 0; b < 7; b++) begin
            for (int j = b; j < 57; j += 7) begin
                p[b] = p[b] ^ v[j];
            end
        end
        return p;
    endfunction

    always_comb begin
        tl_o = tl_i;
        tl_o.d_user.rsp_intg  = fold7(57'({tl_i.d_opcode, tl_i.d_size, tl_i.d_error}));
        tl_o.d_user.data_intg = fold7(57'(tl_i.d_data));
    end

endmodule

// File: rtl/tlul_uart_tx_dev.sv
// TL-UL register slave feeding a byte FIFO that is serialised as 8N1 on tx_o.
// Registers: 0x0 TXDATA (push), 0x4 STATUS (ro), 0x8 CLKDIV (cycles per bit).
module tlul_uart_tx_dev #(
    parameter int unsigned FifoDepth = 8,
    parameter logic [15:0] ClkDivRst = 16'd434
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o,
    output logic              tx_o,
    output logic              tx_busy_o
);
    import tlul_pkg::*;

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned LvlW = $clog2(FifoDepth + 1);
    localparam logic [LvlW-1:0] FullLvl = LvlW'(FifoDepth);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic            rsp_pending;
    logic [15:0]     clkdiv;
    logic [7:0]      fifo_mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [LvlW-1:0] level;
    logic            full, empty, push, pop;
    logic [1:0]      state;
    logic [15:0]     bit_timer, div_eff, reload;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic accept, is_get, is_put, size_ok, sel_tx, sel_st, sel_div, req_ok, req_err, div_we;
    logic [31:0] rdata, lvl_wide;
    logic [3:0]  lvl_sat;

    tl_d_op_e    rsp_op;
    logic [1:0]  rsp_size;
    logic [7:0]  rsp_src;
    logic [31:0] rsp_data;
    logic        rsp_err;
    tl_d2h_t     rsp_raw;

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:4], tl_i.a_mask[3:2],
                         tl_i.a_data[31:16], tl_i.a_user};

    assign accept  = tl_i.a_valid && !rsp_pending;
    assign is_get  = tl_i.a_opcode == Get;
    assign is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign size_ok = tl_i.a_size == 2'd2;
    assign sel_tx  = tl_i.a_address[3:0] == 4'h0;
    assign sel_st  = tl_i.a_address[3:0] == 4'h4;
    assign sel_div = tl_i.a_address[3:0] == 4'h8;
    assign req_ok  = (is_get || is_put) && size_ok && (sel_tx || sel_st || sel_div);

    // A TXDATA push into a full FIFO is the only legal access that still reports an error.
    assign push    = accept && req_ok && is_put && sel_tx && tl_i.a_mask[0] && !full;
    assign req_err = !req_ok || (is_put && sel_tx && tl_i.a_mask[0] && full);
    assign div_we  = accept && req_ok && is_put && sel_div;

    assign lvl_wide = 32'(level);
    assign lvl_sat  = (lvl_wide > 32'd15) ? 4'hF : lvl_wide[3:0];

    always_comb begin
        rdata = '0;
        if (req_ok && is_get) begin
            if (sel_st) begin
                rdata = {24'h0, lvl_sat, 1'b0, tx_busy_o, empty, full};
            end else if (sel_div) begin
                rdata = {16'h0, clkdiv};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_pending <= 1'b0;
        end else if (accept) begin
            rsp_pending <= 1'b1;
        end else if (rsp_pending && tl_i.d_ready) begin
            rsp_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            rsp_op   <= is_get ? AccessAckData : AccessAck;
            rsp_size <= tl_i.a_size;
            rsp_src  <= tl_i.a_source;
            rsp_data <= req_err ? 32'h0 : rdata;
            rsp_err  <= req_err;
        end
    end

    always_comb begin
        rsp_raw          = '0;
        rsp_raw.d_valid  = rsp_pending;
        rsp_raw.d_opcode = rsp_op;
        rsp_raw.d_size   = rsp_size;
        rsp_raw.d_source = rsp_src;
        rsp_raw.d_data   = rsp_data;
        rsp_raw.d_error  = rsp_err;
        rsp_raw.a_ready  = !rsp_pending;
    end

    tlul_rsp_intg_gen u_rsp_intg (
        .tl_i (rsp_raw),
        .tl_o (tl_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkdiv <= ClkDivRst;
        end else if (div_we) begin
            if (tl_i.a_mask[0]) clkdiv[7:0]  <= tl_i.a_data[7:0];
            if (tl_i.a_mask[1]) clkdiv[15:8] <= tl_i.a_data[15:8];
        end
    end

    assign full  = level == FullLvl;
    assign empty = level == '0;
    assign pop   = (state == StIdle) && !empty;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= tl_i.a_data[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // The divisor is sampled at every reload, so a CLKDIV write lands on the next bit boundary.
    assign div_eff = (clkdiv == 16'h0) ? 16'd1 : clkdiv;
    assign reload  = div_eff - 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= StIdle;
            bit_timer <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (!empty) begin
                        state     <= StStart;
                        bit_timer <= reload;
                    end
                end
                StStart: begin
                    if (bit_timer == 16'h0) begin
                        state     <= StData;
                        bit_timer <= reload;
                        bit_idx   <= '0;
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                StData: begin
                    if (bit_timer == 16'h0) begin
                        bit_timer <= reload;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                default: begin
                    if (bit_timer == 16'h0) begin
                        state <= StIdle;
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop) begin
            shift <= fifo_mem[rd_ptr];
        end else if ((state == StData) && (bit_timer == 16'h0)) begin
            shift <= shift >> 1;
        end
    end

    // Decoded from state so that reset forces the line idle without waiting for a clock.
    assign tx_o      = (state == StData) ? shift[0] : (state != StStart);
    assign tx_busy_o = state != StIdle;

endmodule

// File: tb/tb_tlul_uart_tx_dev.sv
// Directed bench for tlul_uart_tx_dev: register accesses, handshake back-pressure,
// FIFO full behaviour, 8N1 frame shape and asynchronous reset mid-frame.
module tb_tlul_uart_tx_dev;
    import tlul_pkg::*;

    logic    clk = 1'b0;
    logic    rst_ni;
    tl_h2d_t tl_i;
    tl_d2h_t tl_o;
    logic    tx_o;
    logic    tx_busy_o;

    always #5 clk = ~clk;

    tlul_uart_tx_dev #(
        .FifoDepth (8),
        .ClkDivRst (16'd434)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .tl_i      (tl_i),
        .tl_o      (tl_o),
        .tx_o      (tx_o),
        .tx_busy_o (tx_busy_o)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic        err;
        logic [31:0] data;
        logic [7:0]  src;
        logic [1:0]  size;
    } rsp_t;

    rsp_t       exp_q[$];
    rsp_t       obs_mem [0:255];
    int         rsp_cnt = 0;
    int         rd_idx = 0;
    int         n_pass = 0;
    int         n_checks = 0;
    logic [7:0] src_id = 8'h0;

    // Capture each D-channel beat at the negedge before its handshake edge.
    always @(negedge clk) begin
        if (tl_o.d_valid && tl_i.d_ready) begin
            obs_mem[rsp_cnt[7:0]] <= {tl_o.d_opcode, tl_o.d_error, tl_o.d_data,
                                      tl_o.d_source, tl_o.d_size};
            rsp_cnt <= rsp_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] mask,
                             input logic [1:0] size, input logic exp_err,
                             input logic [31:0] exp_data);
        rsp_t e;
        e.op   = (op == 3'h4) ? 3'h1 : 3'h0;
        e.err  = exp_err;
        e.data = exp_data;
        e.src  = src_id;
        e.size = size;
        exp_q.push_back(e);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = tl_a_op_e'(op);
        tl_i.a_address = addr;
        tl_i.a_data    = data;
        tl_i.a_mask    = mask;
        tl_i.a_size    = size;
        tl_i.a_source  = src_id;
        src_id         = src_id + 8'd1;
    endtask

    task automatic finish_req();
        int g;
        g = 0;
        while (tl_o.a_ready !== 1'b1 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("a_ready_at_accept", 32'(tl_o.a_ready), 32'd1);
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int   g;
        rsp_t e;
        rsp_t o;
        g = 0;
        while (rsp_cnt <= rd_idx && g < 200) begin
            @(negedge clk);
            g++;
        end
        e = exp_q.pop_front();
        if (rsp_cnt <= rd_idx) begin
            chk({tag, "_timeout"}, 32'(rsp_cnt), 32'(rd_idx + 1));
        end else begin
            o = obs_mem[rd_idx[7:0]];
            rd_idx++;
            chk({tag, "_err"}, 32'(o.err), 32'(e.err));
            chk({tag, "_data"}, o.data, e.data);
            chk({tag, "_opcode"}, 32'(o.op), 32'(e.op));
            chk({tag, "_src_size"}, 32'({o.src, o.size}), 32'({e.src, e.size}));
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [1:0] size, input logic exp_err,
                       input logic [31:0] exp_data, input string tag);
        @(posedge clk); #1;
        drive_req(op, addr, data, mask, size, exp_err, exp_data);
        finish_req();
        wait_rsp(tag);
    endtask

    initial begin
        int         g;
        int         n;
        logic [9:0] bits;

        tl_i         = '0;
        tl_i.d_ready = 1'b1;
        rst_ni       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(tx_busy_o), 32'd0);
        chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
        chk("rst_a_ready", 32'(tl_o.a_ready), 32'd1);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        req(3'h4, 32'h4, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0000_0002, "rd_status_rst");
        req(3'h4, 32'h8, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0000_01B2, "rd_clkdiv_rst");
        req(3'h0, 32'h8, 32'h4, 4'hF, 2'd2, 1'b0, 32'h0, "wr_clkdiv4");
        req(3'h0, 32'h0, 32'hA5, 4'h1, 2'd2, 1'b0, 32'h0, "wr_txdata_a5");

        g = 0;
        while (tx_o !== 1'b0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("frame_start", 32'(tx_o), 32'd0);
        bits = {1'b1, 8'hA5, 1'b0};
        n = 0;
        while (tx_busy_o === 1'b1 && n < 100) begin
            if ((n % 4 == 2) && (n / 4 < 10)) begin
                chk($sformatf("frame_bit%0d", n / 4), 32'(tx_o), 32'(bits[n / 4]));
            end
            @(negedge clk);
            n++;
        end
        chk("busy_len", 32'(n), 32'd40);
        chk("idle_tx", 32'(tx_o), 32'd1);

        // Back-pressure: response held while d_ready is low, second request must wait.
        @(posedge clk); #1;
        tl_i.d_ready = 1'b0;
        drive_req(3'h0, 32'h8, 32'h4, 4'hF, 2'd2, 1'b0, 32'h0);
        finish_req();
        drive_req(3'h4, 32'h8, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0000_0004);
        repeat (5) begin
            @(negedge clk);
            chk("hold_d_valid", 32'(tl_o.d_valid), 32'd1);
            chk("hold_a_ready", 32'(tl_o.a_ready), 32'd0);
        end
        chk("hold_no_handshake", 32'(rsp_cnt), 32'(rd_idx));
        @(posedge clk); #1;
        tl_i.d_ready = 1'b1;
        finish_req();
        wait_rsp("hold_first");
        wait_rsp("hold_second");

        req(3'h4, 32'hC, 32'h0, 4'hF, 2'd2, 1'b1, 32'h0, "rd_unmapped");
        req(3'h0, 32'h8, 32'h10, 4'hF, 2'd1, 1'b1, 32'h0, "wr_size1");
        req(3'h3, 32'h8, 32'h10, 4'hF, 2'd2, 1'b1, 32'h0, "bad_opcode");
        req(3'h4, 32'h0, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0, "rd_txdata");
        req(3'h4, 32'h8, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0000_0004, "rd_clkdiv_kept");
        req(3'h4, 32'h4, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0000_0002, "rd_status_kept");
        req(3'h1, 32'h8, 32'h0000_0100, 4'h2, 2'd2, 1'b0, 32'h0, "wr_clkdiv_hi");
        req(3'h4, 32'h8, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0000_0104, "rd_clkdiv_partial");
        req(3'h0, 32'h8, 32'h4, 4'hF, 2'd2, 1'b0, 32'h0, "wr_clkdiv_restore");

        for (int i = 0; i < 9; i++) begin
            req(3'h0, 32'h0, 32'(8'h30 + i), 4'h1, 2'd2, 1'b0, 32'h0,
                $sformatf("push%0d", i));
        end
        req(3'h0, 32'h0, 32'h55, 4'h1, 2'd2, 1'b1, 32'h0, "push_full");
        req(3'h1, 32'h0, 32'h66, 4'hE, 2'd2, 1'b0, 32'h0, "txdata_nomask");
        req(3'h4, 32'h4, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0000_0085, "rd_status_full");

        // Find the next frame and reset the block in the middle of data bit 3.
        g = 0;
        while (tx_busy_o !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        g = 0;
        while (tx_o !== 1'b0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("rst_frame_start", 32'(tx_o), 32'd0);
        repeat (4 + 3 * 4 + 2) @(negedge clk);
        chk("mid_bit3_busy", 32'(tx_busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx_o), 32'd1);
        chk("async_rst_busy", 32'(tx_busy_o), 32'd0);
        chk("async_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        req(3'h4, 32'h4, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0000_0002, "rd_status_after_rst");
        req(3'h4, 32'h8, 32'h0, 4'hF, 2'd2, 1'b0, 32'h0000_01B2, "rd_clkdiv_after_rst");
        repeat (5) @(negedge clk);
        chk("post_rst_tx_idle", 32'(tx_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
